// File: rtl/filt_fir_mc_pkg.sv
// Shared definitions for the multi-channel serial-MAC FIR filter:
// derived-size helpers and the sequencer state encoding.

`define FILT_CEIL_DIV(a, b) (((a) + (b) - 32'sd1) / (b))

package filt_fir_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } fir_state_e;

    // Stored coefficients: folded half (rounded up) when symmetric, else all taps.
    function automatic int f_ncoeff(input int len, input int symm);
        if (symm != 32'sd0) begin
            return `FILT_CEIL_DIV(len, 32'sd2);
        end else begin
            return len;
        end
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int f_idx_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 32'sd1) ? 32'sd1 : w;
    endfunction

    // Accumulator width: pre-add growth plus growth over all taps.
    function automatic int f_acc_width(input int inp_w, input int coeff_w,
                                       input int len, input int symm);
        return inp_w + ((symm != 32'sd0) ? 32'sd1 : 32'sd0) + coeff_w + $clog2(len);
    endfunction

endpackage

// File: rtl/filt_rnd_sat.sv
// Combinational round-half-up, arithmetic right shift and saturation of a
// signed value to a narrower signed output. Reusable by other filters.

module filt_rnd_sat #(
    parameter int gp_in_width  = 24,
    parameter int gp_shift     = 8,
    parameter int gp_out_width = 16
) (
    input  logic signed [gp_in_width-1:0]  i_data,
    output logic signed [gp_out_width-1:0] o_data
);

    localparam int c_sum_w   = gp_in_width + 1;
    localparam int c_cmp_w   = ((c_sum_w > gp_out_width) ? c_sum_w : gp_out_width) + 1;
    localparam int c_rnd_pos = (gp_shift > 0) ? (gp_shift - 1) : 0;

    localparam logic [c_sum_w-1:0] c_sum_one = {{(c_sum_w-1){1'b0}}, 1'b1};
    localparam logic [c_sum_w-1:0] c_half    = (gp_shift > 0) ? (c_sum_one << c_rnd_pos)
                                                              : {c_sum_w{1'b0}};
    localparam logic [c_cmp_w-1:0] c_cmp_one = {{(c_cmp_w-1){1'b0}}, 1'b1};
    localparam logic signed [c_cmp_w-1:0] c_max = (c_cmp_one << (gp_out_width-1)) - c_cmp_one;
    localparam logic signed [c_cmp_w-1:0] c_min = {c_cmp_w{1'b0}} - (c_cmp_one << (gp_out_width-1));

    logic signed [c_sum_w-1:0] sum_s;
    logic signed [c_sum_w-1:0] shr_s;
    logic signed [c_cmp_w-1:0] ext_s;

    // Round (extra headroom bit prevents overflow), shift, then clamp.
    always_comb begin
        sum_s = {i_data[gp_in_width-1], i_data} + c_half;
        shr_s = sum_s >>> gp_shift;
        ext_s = c_cmp_w'(shr_s);
        if (ext_s > c_max) begin
            o_data = c_max[gp_out_width-1:0];
        end else if (ext_s < c_min) begin
            o_data = c_min[gp_out_width-1:0];
        end else begin
            o_data = ext_s[gp_out_width-1:0];
        end
    end

endmodule

// File: rtl/filt_fir_mc.sv
// Multi-channel time-multiplexed FIR: one sample at a time is filtered with a
// single serial MAC over the stored coefficients (optionally symmetric with
// pre-add folding), then rounded/saturated and presented with o_valid.

module filt_fir_mc
    import filt_fir_mc_pkg::*;
#(
    parameter int gp_inp_width    = 8,
    parameter int gp_coeff_width  = 8,
    parameter int gp_coeff_length = 17,
    parameter int gp_nchan        = 2,
    parameter int gp_symm         = 1,
    parameter int gp_oup_shift    = 8,
    parameter int gp_oup_width    = 16,
    localparam int c_ncoeff    = f_ncoeff(gp_coeff_length, gp_symm),
    localparam int c_chan_w    = f_idx_width(gp_nchan),
    localparam int c_addr_w    = f_idx_width(c_ncoeff)
) (
    input  logic                             i_clk,
    input  logic                             i_rst_an,
    input  logic                             i_ena,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [c_chan_w-1:0]              i_chan,
    input  logic signed [gp_inp_width-1:0]   i_data,
    input  logic                             i_coeff_we,
    input  logic [c_addr_w-1:0]              i_coeff_addr,
    input  logic signed [gp_coeff_width-1:0] i_coeff_data,
    output logic                             o_coeff_err,
    output logic                             o_valid,
    output logic [c_chan_w-1:0]              o_chan,
    output logic signed [gp_oup_width-1:0]   o_data
);

    localparam int c_acc_width = f_acc_width(gp_inp_width, gp_coeff_width, gp_coeff_length, gp_symm);
    localparam int c_ptr_w     = $clog2(gp_coeff_length);
    localparam int c_pre_w     = gp_inp_width + 1;
    localparam int c_prod_w    = c_pre_w + gp_coeff_width;
    localparam bit c_has_centre = (gp_symm != 0) && ((gp_coeff_length % 2) == 1);

    localparam logic [c_ptr_w:0]    c_len_x  = (c_ptr_w+1)'(gp_coeff_length);
    localparam logic [c_ptr_w-1:0]  c_ptr_lst = c_ptr_w'(gp_coeff_length - 1);
    localparam logic [c_ptr_w-1:0]  c_ptr_one = {{(c_ptr_w-1){1'b0}}, 1'b1};
    localparam logic [c_addr_w-1:0] c_k_last = c_addr_w'(c_ncoeff - 1);
    localparam logic [c_addr_w-1:0] c_k_one  = {{(c_addr_w-1){1'b0}}, 1'b1};

    logic signed [gp_coeff_width-1:0] coeff_r [c_ncoeff];
    logic signed [gp_inp_width-1:0]   dline_r [gp_nchan][gp_coeff_length];
    logic [c_ptr_w-1:0]               wptr_r  [gp_nchan];

    fir_state_e                state_r;
    logic [c_chan_w-1:0]       chan_r;
    logic [c_ptr_w-1:0]        base_r;
    logic [c_addr_w-1:0]       k_r;
    logic signed [c_acc_width-1:0] acc_r;

    logic                      accept_s;
    logic                      chan_ok_s;
    logic                      coeff_ok_s;
    logic [c_ptr_w:0]          sum_a_s;
    logic [c_ptr_w:0]          sum_b_s;
    logic [c_ptr_w-1:0]        idx_a_s;
    logic [c_ptr_w-1:0]        idx_b_s;
    logic signed [gp_inp_width-1:0] x_a_s;
    logic signed [gp_inp_width-1:0] x_b_s;
    logic signed [c_pre_w-1:0]  pre_s;
    logic signed [c_prod_w-1:0] prod_s;
    logic signed [c_acc_width-1:0] acc_nxt_s;
    logic signed [gp_oup_width-1:0] rs_s;

    // Handshake and write-legality decode.
    always_comb begin
        accept_s   = i_ena & i_valid & o_ready;
        chan_ok_s  = ({1'b0, i_chan} < (c_chan_w+1)'(gp_nchan));
        coeff_ok_s = (state_r == ST_IDLE) && ({1'b0, i_coeff_addr} < (c_addr_w+1)'(c_ncoeff));
    end

    // Tap fetch: newest-minus-k and its mirror partner, pre-add, multiply, accumulate.
    always_comb begin
        sum_a_s = {1'b0, base_r} + c_len_x - (c_ptr_w+1)'(k_r);
        sum_b_s = {1'b0, base_r} + (c_ptr_w+1)'(c_ptr_one) + (c_ptr_w+1)'(k_r);
        if (sum_a_s >= c_len_x) begin
            idx_a_s = c_ptr_w'(sum_a_s - c_len_x);
        end else begin
            idx_a_s = c_ptr_w'(sum_a_s);
        end
        if (sum_b_s >= c_len_x) begin
            idx_b_s = c_ptr_w'(sum_b_s - c_len_x);
        end else begin
            idx_b_s = c_ptr_w'(sum_b_s);
        end
        x_a_s = dline_r[chan_r][idx_a_s];
        x_b_s = dline_r[chan_r][idx_b_s];
        // The centre tap of an odd symmetric filter has no mirror partner.
        if ((gp_symm != 0) && !(c_has_centre && (k_r == c_k_last))) begin
            pre_s = {x_a_s[gp_inp_width-1], x_a_s} + {x_b_s[gp_inp_width-1], x_b_s};
        end else begin
            pre_s = {x_a_s[gp_inp_width-1], x_a_s};
        end
        prod_s = pre_s * coeff_r[k_r];
        if (k_r == {c_addr_w{1'b0}}) begin
            acc_nxt_s = c_acc_width'(prod_s);
        end else begin
            acc_nxt_s = acc_r + c_acc_width'(prod_s);
        end
    end

    filt_rnd_sat #(
        .gp_in_width  (c_acc_width),
        .gp_shift     (gp_oup_shift),
        .gp_out_width (gp_oup_width)
    ) u_rnd_sat (
        .i_data (acc_r),
        .o_data (rs_s)
    );

    // Per-channel circular delay lines and write pointers.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            for (int c = 32'sd0; c < gp_nchan; c++) begin
                wptr_r[c] <= '0;
                for (int t = 32'sd0; t < gp_coeff_length; t++) begin
                    dline_r[c][t] <= '0;
                end
            end
        end else if (accept_s && chan_ok_s) begin
            dline_r[i_chan][wptr_r[i_chan]] <= i_data;
            wptr_r[i_chan] <= (wptr_r[i_chan] == c_ptr_lst) ? '0 : (wptr_r[i_chan] + c_ptr_one);
        end
    end

    // Coefficient bank: writes only while idle and in range, otherwise flag an error.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            for (int i = 32'sd0; i < c_ncoeff; i++) begin
                coeff_r[i] <= '0;
            end
            o_coeff_err <= 1'b0;
        end else if (i_ena) begin
            if (i_coeff_we && coeff_ok_s) begin
                coeff_r[i_coeff_addr] <= i_coeff_data;
                o_coeff_err <= 1'b0;
            end else begin
                o_coeff_err <= i_coeff_we;
            end
        end
    end

    // Sequencer: IDLE -> MAC (one tap per cycle) -> OUT, with registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            state_r <= ST_IDLE;
            chan_r  <= '0;
            base_r  <= '0;
            k_r     <= '0;
            acc_r   <= '0;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            o_chan  <= '0;
            o_data  <= '0;
        end else if (i_ena) begin
            case (state_r)
                ST_IDLE: begin
                    o_valid <= 1'b0;
                    if (accept_s && chan_ok_s) begin
                        state_r <= ST_MAC;
                        chan_r  <= i_chan;
                        base_r  <= wptr_r[i_chan];
                        k_r     <= '0;
                        o_ready <= 1'b0;
                    end
                end
                ST_MAC: begin
                    o_valid <= 1'b0;
                    acc_r   <= acc_nxt_s;
                    if (k_r == c_k_last) begin
                        state_r <= ST_OUT;
                    end else begin
                        k_r <= k_r + c_k_one;
                    end
                end
                ST_OUT: begin
                    o_data  <= rs_s;
                    o_chan  <= chan_r;
                    o_valid <= 1'b1;
                    o_ready <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    o_ready <= 1'b1;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_filt_fir_mc.sv
// Scoreboard bench: two instances (shift 0 / 16-bit and shift 1 / 8-bit) share
// stimulus; directed samples carry hand-computed accumulator values.

module tb_filt_fir_mc;

    logic              clk;
    logic              rst_n;
    logic              ena;
    logic              valid;
    logic              chan;
    logic signed [7:0] data;
    logic              cwe;
    logic [1:0]        caddr;
    logic signed [7:0] cdata;

    logic               rdy0, cerr0, ov0, och0;
    logic signed [15:0] od0;
    logic               rdy1, cerr1, ov1, och1;
    logic signed [7:0]  od1;

    typedef struct {
        int ch;
        int acc;
        int cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;

    filt_fir_mc #(
        .gp_inp_width(8), .gp_coeff_width(8), .gp_coeff_length(5), .gp_nchan(2),
        .gp_symm(1), .gp_oup_shift(0), .gp_oup_width(16)
    ) dut0 (
        .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .i_valid(valid), .o_ready(rdy0),
        .i_chan(chan), .i_data(data), .i_coeff_we(cwe), .i_coeff_addr(caddr),
        .i_coeff_data(cdata), .o_coeff_err(cerr0), .o_valid(ov0), .o_chan(och0), .o_data(od0)
    );

    filt_fir_mc #(
        .gp_inp_width(8), .gp_coeff_width(8), .gp_coeff_length(5), .gp_nchan(2),
        .gp_symm(1), .gp_oup_shift(1), .gp_oup_width(8)
    ) dut1 (
        .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .i_valid(valid), .o_ready(rdy1),
        .i_chan(chan), .i_data(data), .i_coeff_we(cwe), .i_coeff_addr(caddr),
        .i_coeff_data(cdata), .o_coeff_err(cerr1), .o_valid(ov1), .o_chan(och1), .o_data(od1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sat16(input int a);
        if (a > 32767) return 32767;
        else if (a < -32768) return -32768;
        else return a;
    endfunction

    function automatic int rnd8(input int a);
        int r;
        r = (a + 1) >>> 1;
        if (r > 127) return 127;
        else if (r < -128) return -128;
        else return r;
    endfunction

    task automatic check(input string name, input int act, input int req);
        nvec++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Wait (bounded) for o_ready at a falling edge; returns 1 when seen.
    task automatic wait_ready(output bit ok);
        int t;
        t = 0;
        @(negedge clk);
        while (!rdy0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        ok = rdy0;
        if (!ok) check("ready_timeout", 0, 1);
    endtask

    task automatic send(input int ch, input int x, input int acc, input int stall, input bit push);
        bit ok;
        wait_ready(ok);
        if (ok) begin
            chan  = ch[0];
            data  = x[7:0];
            valid = 1'b1;
            @(posedge clk);
            #1;
            if (push) begin
                q0.push_back('{ch: ch, acc: acc, cyc: cyc + 4 + stall});
                q1.push_back('{ch: ch, acc: acc, cyc: cyc + 4 + stall});
            end
            valid = 1'b0;
        end
    endtask

    task automatic coeff_wr(input int addr, input int val, input bit exp_err, input bit idle);
        bit ok;
        if (idle) wait_ready(ok);
        else @(negedge clk);
        cwe   = 1'b1;
        caddr = addr[1:0];
        cdata = val[7:0];
        @(posedge clk);
        #1;
        check("coeff_err0", int'(cerr0), int'(exp_err));
        check("coeff_err1", int'(cerr1), int'(exp_err));
        cwe = 1'b0;
    endtask

    task automatic check_reset_vals();
        check("rst_ready", int'(rdy0), 1);
        check("rst_valid", int'(ov0), 0);
        check("rst_chan",  int'(och0), 0);
        check("rst_data",  int'(od0), 0);
        check("rst_cerr",  int'(cerr0), 0);
        check("rst_data1", int'(od1), 0);
    endtask

    // Monitor: pop the expected response whenever either instance presents one.
    always @(negedge clk) begin
        if (rst_n && ov0) begin
            if (q0.size() == 0) begin
                check("out0_unexpected", int'(od0), 99999);
            end else begin
                e0 = q0.pop_front();
                check("out0_data", int'(od0), sat16(e0.acc));
                check("out0_chan", int'(och0), e0.ch);
                check("out0_latency", cyc, e0.cyc);
            end
        end
        if (rst_n && ov1) begin
            if (q1.size() == 0) begin
                check("out1_unexpected", int'(od1), 99999);
            end else begin
                e1 = q1.pop_front();
                check("out1_data", int'(od1), rnd8(e1.acc));
                check("out1_chan", int'(och1), e1.ch);
            end
        end
    end

    initial begin
        rst_n = 1'b0; ena = 1'b1; valid = 1'b0; chan = 1'b0; data = '0;
        cwe = 1'b0; caddr = '0; cdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_reset_vals();

        // Coefficients [1,2,3] -> taps 1,2,3,2,1
        coeff_wr(0, 1, 1'b0, 1'b1);
        coeff_wr(1, 2, 1'b0, 1'b1);
        coeff_wr(2, 3, 1'b0, 1'b1);

        // Impulse on ch0
        send(0, 1, 1, 0, 1'b1); send(0, 0, 2, 0, 1'b1); send(0, 0, 3, 0, 1'b1);
        send(0, 0, 2, 0, 1'b1); send(0, 0, 1, 0, 1'b1);

        // ch0 impulse interleaved with ch1 constant 10
        send(0, 1, 1, 0, 1'b1);  send(1, 10, 10, 0, 1'b1);
        send(0, 0, 2, 0, 1'b1);  send(1, 10, 30, 0, 1'b1);
        send(0, 0, 3, 0, 1'b1);  send(1, 10, 60, 0, 1'b1);
        send(0, 0, 2, 0, 1'b1);  send(1, 10, 80, 0, 1'b1);
        send(0, 0, 1, 0, 1'b1);  send(1, 10, 90, 0, 1'b1);
        send(1, 10, 90, 0, 1'b1);

        // Rounding: acc 3 and -3 (shift-1 instance gives 2 and -1)
        send(0, 3, 3, 0, 1'b1);  send(0, 0, 6, 0, 1'b1); send(0, 0, 9, 0, 1'b1);
        send(0, 0, 6, 0, 1'b1);  send(0, 0, 3, 0, 1'b1); send(0, -3, -3, 0, 1'b1);

        // Saturation: coefficients 127, ch1 history all 10
        coeff_wr(0, 127, 1'b0, 1'b1);
        coeff_wr(1, 127, 1'b0, 1'b1);
        coeff_wr(2, 127, 1'b0, 1'b1);
        send(1, 127, 21209, 0, 1'b1); send(1, 127, 36068, 0, 1'b1);
        send(1, 127, 50927, 0, 1'b1); send(1, 127, 65786, 0, 1'b1);
        send(1, 127, 80645, 0, 1'b1);
        send(1, -128, 48260, 0, 1'b1);  send(1, -128, 15875, 0, 1'b1);
        send(1, -128, -16510, 0, 1'b1); send(1, -128, -48895, 0, 1'b1);
        send(1, -128, -81280, 0, 1'b1);

        // Coefficient rules
        coeff_wr(0, 1, 1'b0, 1'b1);
        coeff_wr(1, 2, 1'b0, 1'b1);
        coeff_wr(2, 3, 1'b0, 1'b1);
        send(0, 0, -6, 0, 1'b1); send(0, 0, -9, 0, 1'b1);
        send(0, 0, -6, 0, 1'b1); send(0, 0, -3, 0, 1'b1);
        send(0, 1, 1, 0, 1'b1);
        coeff_wr(1, 50, 1'b1, 1'b0);
        send(0, 0, 2, 0, 1'b1); send(0, 0, 3, 0, 1'b1);
        send(0, 0, 2, 0, 1'b1); send(0, 0, 1, 0, 1'b1);
        coeff_wr(3, 7, 1'b1, 1'b1);
        coeff_wr(0, 4, 1'b0, 1'b1);
        send(0, 1, 4, 0, 1'b1); send(0, 0, 2, 0, 1'b1); send(0, 0, 3, 0, 1'b1);
        send(0, 0, 2, 0, 1'b1); send(0, 0, 4, 0, 1'b1);

        // Stall: i_ena low for 3 cycles mid-MAC
        send(0, 5, 20, 3, 1'b1);
        @(negedge clk);
        ena = 1'b0;
        repeat (3) @(negedge clk);
        ena = 1'b1;
        send(0, 0, 10, 0, 1'b1);

        // Reset mid-MAC: no output, history and coefficients cleared
        send(1, 7, 0, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_vals();
        repeat (8) @(negedge clk);
        coeff_wr(0, 1, 1'b0, 1'b1);
        coeff_wr(1, 2, 1'b0, 1'b1);
        coeff_wr(2, 3, 1'b0, 1'b1);
        send(1, 1, 1, 0, 1'b1); send(1, 0, 2, 0, 1'b1);

        // Drain the scoreboard
        for (int i = 0; i < 100 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("q0_drain", q0.size(), 0);
        check("q1_drain", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
